// File: rtl/mem_wait_ctrl.sv
`timescale 1ns/1ps
// Unified instruction/data memory for the multicycle MIPS core.
// Each request completes after WAIT_CYCLES extra cycles with a one-cycle o_ready pulse.
module mem_wait_ctrl #(
  parameter int    ADDR_W      = 8,
  parameter int    WAIT_CYCLES = 2,
  parameter string MEM_INIT    = ""
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_addr_err,
  output logic [1:0]  o_dbg_state
);

  // Handshake: i_req is sampled only while IDLE; the accepted access completes with a
  // one-cycle o_ready (qualified by o_addr_err). The block is IDLE during that cycle, so
  // an i_req still high there is a new, distinct access.

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_wait_ctrl: WAIT_CYCLES=%0d outside 0..15", WAIT_CYCLES);
  end

  logic [31:0] mem [0:(2**ADDR_W)-1];

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              aerr_q, aerr_d;
  logic              mem_we;
  logic              acc_err;

  // Misaligned, or any byte-address bit above the RAM range set.
  assign acc_err = (i_addr[1:0] != 2'b00) || ((i_addr >> (ADDR_W + 2)) != 32'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    aerr_d  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          we_d    = i_we;
          idx_d   = i_addr[ADDR_W+1:2];
          wdata_d = i_wdata;
          err_d   = acc_err;
          busy_d  = 1'b1;
          cnt_d   = WAIT_INIT;
          if (acc_err || WAIT_CYCLES == 0) state_d = S_ACCESS;
          else                             state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (err_q)     aerr_d  = 1'b1;
        else if (we_q) mem_we  = 1'b1;
        else           rdata_d = mem[idx_q];
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      aerr_q  <= aerr_d;
    end
  end

  // RAM contents survive reset; a reset mid-access forces IDLE so mem_we never fires.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  assign o_rdata     = rdata_q;
  assign o_ready     = ready_q;
  assign o_busy      = busy_q;
  assign o_addr_err  = aerr_q;
  assign o_dbg_state = state_q;

endmodule
